pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed MEM/WB latch of the five-stage MIPS pipeline; one instance per inter-stage boundary (D/E, E/M, M/W).
- Carries destination register, result data, PC and a Tnew (cycles-until-result-ready) tag for the hazard unit.
- Adds stall (hold) and flush (bubble insert), a valid bit, a derived register-write strobe and a saturating stall-cycle counter.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_stage_reg_sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 87 ++++++++
 tb/tb_pipe_stage_reg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-zero constant, default field widths
// and the Tnew saturating decrement used by stage registers and the hazard unit.
package pipe_pkg;

  localparam logic [4:0] REG_ZERO   = 5'd0;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int TNEW_W_DEF = 2;

  // Callers may use narrower Tnew tags; they widen into this and truncate back.
  localparam int TNEW_MAX_W = 8;

  typedef logic [TNEW_MAX_W-1:0] tnew_wide_t;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_RESET   = 2'd3
  } stage_action_e;

  // Saturating decrement: a result already available stays at zero.
  function automatic tnew_wide_t tnew_dec(input tnew_wide_t t);
    tnew_wide_t r;
    if (t == '0) r = '0;
    else         r = t - tnew_wide_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic at_max;

  assign at_max = (count == {CNT_W{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (clear)
      count <= '0;
    else if (inc && !at_max)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush, valid tracking, Tnew ageing
// and a saturating count of stalled cycles.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TNEW_W         = TNEW_W_DEF,
  parameter int CNT_W          = 16,
  parameter bit BUBBLE_KEEP_PC = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ValidIn,
  input  logic [ADDR_W-1:0] A3In,
  input  logic [DATA_W-1:0] WDIn,
  input  logic [31:0]       PCIn,
  input  logic [TNEW_W-1:0] TnewIn,
  output logic              ValidOut,
  output logic [ADDR_W-1:0] A3Out,
  output logic [DATA_W-1:0] WDOut,
  output logic [31:0]       PCOut,
  output logic [TNEW_W-1:0] TnewOut,
  output logic              RegWriteOut,
  output logic [CNT_W-1:0]  StallCnt
);

  stage_action_e action;
  tnew_wide_t    tnew_in_wide;
  logic [TNEW_W-1:0] tnew_next;
  logic [ADDR_W-1:0] a3_next;
  logic [31:0]       bubble_pc;

  always_comb begin
    action = ACT_ADVANCE;
    if (Reset)      action = ACT_RESET;
    else if (Flush) action = ACT_FLUSH;
    else if (Stall) action = ACT_STALL;
  end

  // An empty slot never produces a result, so its Tnew and destination are zeroed.
  assign tnew_in_wide = tnew_wide_t'(TnewIn);
  assign tnew_next    = ValidIn ? TNEW_W'(tnew_dec(tnew_in_wide)) : '0;
  assign a3_next      = ValidIn ? A3In : '0;
  assign bubble_pc    = BUBBLE_KEEP_PC ? PCIn : 32'd0;

  always_ff @(posedge Clk) begin
    case (action)
      ACT_RESET: begin
        ValidOut <= 1'b0;
        A3Out    <= '0;
        WDOut    <= '0;
        PCOut    <= '0;
        TnewOut  <= '0;
      end
      ACT_FLUSH: begin
        ValidOut <= 1'b0;
        A3Out    <= '0;
        WDOut    <= '0;
        PCOut    <= bubble_pc;
        TnewOut  <= '0;
      end
      ACT_ADVANCE: begin
        ValidOut <= ValidIn;
        A3Out    <= a3_next;
        WDOut    <= WDIn;
        PCOut    <= PCIn;
        TnewOut  <= tnew_next;
      end
      default: ;
    endcase
  end

  assign RegWriteOut = ValidOut && (A3Out != ADDR_W'(REG_ZERO));

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .Clk   (Clk),
    .clear (Reset),
    .inc   (Stall && !Flush),
    .count (StallCnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a PC-zeroing bubble
// variant and a 4-bit stall counter variant sharing the same stimulus.
module tb_pipe_stage_reg;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, ValidIn;
  logic [4:0]  A3In;
  logic [31:0] WDIn, PCIn;
  logic [1:0]  TnewIn;

  logic        v_a, v_b, v_c, rw_a, rw_b, rw_c;
  logic [4:0]  a3_a, a3_b, a3_c;
  logic [31:0] wd_a, wd_b, wd_c, pc_a, pc_b, pc_c;
  logic [1:0]  t_a, t_b, t_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int tests = 0;
  int failed = 0;

  always #5 Clk = ~Clk;

  pipe_stage_reg dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .A3In(A3In), .WDIn(WDIn), .PCIn(PCIn), .TnewIn(TnewIn),
    .ValidOut(v_a), .A3Out(a3_a), .WDOut(wd_a), .PCOut(pc_a), .TnewOut(t_a),
    .RegWriteOut(rw_a), .StallCnt(cnt_a)
  );

  pipe_stage_reg #(.BUBBLE_KEEP_PC(1'b0)) dut_nopc (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .A3In(A3In), .WDIn(WDIn), .PCIn(PCIn), .TnewIn(TnewIn),
    .ValidOut(v_b), .A3Out(a3_b), .WDOut(wd_b), .PCOut(pc_b), .TnewOut(t_b),
    .RegWriteOut(rw_b), .StallCnt(cnt_b)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_c4 (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .A3In(A3In), .WDIn(WDIn), .PCIn(PCIn), .TnewIn(TnewIn),
    .ValidOut(v_c), .A3Out(a3_c), .WDOut(wd_c), .PCOut(pc_c), .TnewOut(t_c),
    .RegWriteOut(rw_c), .StallCnt(cnt_c)
  );

  typedef struct {
    logic        stall, flush, valid;
    logic [4:0]  a3;
    logic [31:0] wd, pc;
    logic [1:0]  tnew;
    logic        e_valid;
    logic [4:0]  e_a3;
    logic [31:0] e_wd, e_pc;
    logic [1:0]  e_tnew;
    logic        e_rw;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic [4:0] a3,
                       input logic [31:0] wd, input logic [31:0] pc, input logic [1:0] t);
    Stall = st; Flush = fl; ValidIn = v; A3In = a3; WDIn = wd; PCIn = pc; TnewIn = t;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [4:0] ea3,
                            input logic [31:0] ewd, input logic [31:0] epc,
                            input logic [1:0] et, input logic erw);
    check({tag, ".valid"}, 64'(v_a), 64'(ev));
    check({tag, ".a3"},    64'(a3_a), 64'(ea3));
    check({tag, ".wd"},    64'(wd_a), 64'(ewd));
    check({tag, ".pc"},    64'(pc_a), 64'(epc));
    check({tag, ".tnew"},  64'(t_a), 64'(et));
    check({tag, ".rw"},    64'(rw_a), 64'(erw));
  endtask

  initial begin
    vecs[0] = '{0,0,1, 5'd8,  32'h1234_5678, 32'h0000_3004, 2'd2, 1, 5'd8,  32'h1234_5678, 32'h0000_3004, 2'd1, 1};
    vecs[1] = '{0,0,1, 5'd8,  32'h1234_5678, 32'h0000_3004, 2'd0, 1, 5'd8,  32'h1234_5678, 32'h0000_3004, 2'd0, 1};
    vecs[2] = '{0,0,1, 5'd0,  32'h1234_5678, 32'h0000_3004, 2'd1, 1, 5'd0,  32'h1234_5678, 32'h0000_3004, 2'd0, 0};
    vecs[3] = '{0,0,0, 5'd9,  32'hDEAD_BEEF, 32'h0000_3020, 2'd3, 0, 5'd0,  32'hDEAD_BEEF, 32'h0000_3020, 2'd0, 0};
    vecs[4] = '{0,0,1, 5'd31, 32'hAAAA_5555, 32'h0000_3024, 2'd3, 1, 5'd31, 32'hAAAA_5555, 32'h0000_3024, 2'd2, 1};
    vecs[5] = '{0,1,1, 5'd7,  32'h0000_0001, 32'h0000_3028, 2'd3, 0, 5'd0,  32'h0000_0000, 32'h0000_3028, 2'd0, 0};

    // Reset with every input forced high
    Reset = 1'b1;
    drive(1, 1, 1, 5'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'h3);
    step();
    step();
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    check("reset.cnt", 64'(cnt_a), 64'd0);
    check("reset.nopc_pc", 64'(pc_b), 64'd0);
    check("reset.c4_cnt", 64'(cnt_c), 64'd0);
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].a3,
            vecs[i].wd, vecs[i].pc, vecs[i].tnew);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_a3, vecs[i].e_wd,
                 vecs[i].e_pc, vecs[i].e_tnew, vecs[i].e_rw);
      check($sformatf("vec%0d.nopc_pc", i), 64'(pc_b),
            64'(vecs[i].flush ? 32'd0 : vecs[i].e_pc));
      check($sformatf("vec%0d.cnt", i), 64'(cnt_a), 64'd0);
    end

    // Load 0x3008 then stall three edges while inputs change
    drive(0, 0, 1, 5'd3, 32'hCAFE_0001, 32'h0000_3008, 2'd2);
    step();
    check_outs("load", 1, 5'd3, 32'hCAFE_0001, 32'h0000_3008, 2'd1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, (i % 2) == 0, 5'(i + 10), 32'h5000_0000 + 32'(i), 32'h0000_4000 + 32'(4 * i), 2'd3);
      step();
      check_outs($sformatf("stall%0d", i), 1, 5'd3, 32'hCAFE_0001, 32'h0000_3008, 2'd1, 1);
      check($sformatf("stall%0d.cnt", i), 64'(cnt_a), 64'(i + 1));
    end

    // Release: new data lands after exactly one edge
    drive(0, 0, 1, 5'd4, 32'h0BAD_F00D, 32'h0000_300C, 2'd1);
    step();
    check_outs("release", 1, 5'd4, 32'h0BAD_F00D, 32'h0000_300C, 2'd0, 1);
    check("release.cnt", 64'(cnt_a), 64'd3);

    // Flush overrides stall and leaves the counter alone
    drive(1, 1, 1, 5'd31, 32'hFFFF_FFFF, 32'h0000_3010, 2'd3);
    step();
    check_outs("flush_stall", 0, 0, 0, 32'h0000_3010, 0, 0);
    check("flush_stall.cnt", 64'(cnt_a), 64'd3);
    check("flush_stall.nopc_pc", 64'(pc_b), 64'd0);
    check("flush_stall.nopc_valid", 64'(v_b), 64'd0);
    check("flush_stall.c4_cnt", 64'(cnt_c), 64'd3);

    // Long stall: 4-bit counter saturates at 15, 16-bit keeps counting
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 5'd1, 32'h0000_0099, 32'h0000_5000, 2'd2);
      step();
      check($sformatf("sat%0d.c4_cnt", i), 64'(cnt_c), 64'((3 + i + 1) > 15 ? 15 : (3 + i + 1)));
    end
    check("sat.cnt", 64'(cnt_a), 64'd23);
    check_outs("sat.hold", 0, 0, 0, 32'h0000_3010, 0, 0);

    // Reset arriving mid-stall clears everything including the counters
    Reset = 1'b1;
    drive(1, 1, 1, 5'd5, 32'h1111_1111, 32'h0000_6000, 2'd3);
    step();
    check_outs("rst_mid", 0, 0, 0, 0, 0, 0);
    check("rst_mid.cnt", 64'(cnt_a), 64'd0);
    check("rst_mid.c4_cnt", 64'(cnt_c), 64'd0);
    Reset = 1'b0;

    drive(0, 0, 1, 5'd2, 32'h7777_0000, 32'h0000_3030, 2'd3);
    step();
    check_outs("post_rst", 1, 5'd2, 32'h7777_0000, 32'h0000_3030, 2'd2, 1);
    check("post_rst.nopc_pc", 64'(pc_b), 64'h0000_3030);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
